// File: rtl/dds_lut_ctrl_if.sv
`timescale 1ns/1ps
// Host load stream and sine-SRAM control/read-side signals of the DDS LUT controller.
// The master modport is the controller side; the slave modport is the host/SRAM side.
interface dds_lut_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16
);
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_done;
   logic              cen;
   logic              wen;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] data_wr;
   logic              sign;
   logic              smp_valid;

   modport master (
      input  ld_valid, ld_data,
      output ld_ready, ld_done, cen, wen, index, data_wr, sign, smp_valid
   );

   modport slave (
      output ld_valid, ld_data,
      input  ld_ready, ld_done, cen, wen, index, data_wr, sign, smp_valid
   );
endinterface

// File: rtl/dds_lut_ctrl.sv
`timescale 1ns/1ps
// DDS LUT sequencer: bulk-loads the half-wave sine SRAM, then runs the phase accumulator
// that addresses it. Define PHASE_DITHER_EN to add a 16-bit LFSR dither to the phase.
module dds_lut_ctrl #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic [ACC_W-1:0] fcw,
   input  logic [ACC_W-1:0] phase_off,
   input  logic             phase_clr,
   input  logic             run_en,
   input  logic             ld_start,
   output logic             table_valid,
   dds_lut_ctrl_if.master   bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0] ld_cnt;
   logic [ACC_W-1:0]  phase_p0;
   logic              sign_p1;
   logic              vld_p1;
   logic              ld_ready_r;
   logic              ld_done_r;
   logic              cen_r;
   logic              wen_r;
   logic [ADDR_W-1:0] index_r;
   logic [DATA_W-1:0] data_wr_r;
   logic              sign_r;
   logic              smp_valid_r;
   logic              ld_xfer;
   logic              rd_issue;
   logic              ld_enter;

   // Table address is the phase bits just below the sign (half-wave) bit.
   function automatic logic [ADDR_W-1:0] phase_to_index(input logic [ACC_W-1:0] p);
      return ADDR_W'(p >> (ACC_W - 1 - ADDR_W));
   endfunction

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge sys_clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (state == RUN)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign phase_p0 = acc + phase_off + ACC_W'(lfsr);
`else
   assign phase_p0 = acc + phase_off;
`endif

   assign ld_xfer  = (state == LOAD) && bus.ld_valid && ld_ready_r;
   assign rd_issue = (state == RUN) && run_en && !ld_start;
   assign ld_enter = (state != LOAD) && (state_nxt == LOAD);

   always_ff @(posedge sys_clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (ld_start)
               state_nxt = LOAD;
            else if (run_en && table_valid)
               state_nxt = RUN;
         end
         LOAD: begin
            if (ld_xfer && (ld_cnt == LAST_ADDR))
               state_nxt = IDLE;
         end
         RUN: begin
            if (ld_start)
               state_nxt = LOAD;
            else if (!run_en)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         acc         <= '0;
         ld_cnt      <= '0;
         sign_p1     <= 1'b0;
         vld_p1      <= 1'b0;
         cen_r       <= 1'b1;
         wen_r       <= 1'b1;
         index_r     <= '0;
         data_wr_r   <= '0;
         sign_r      <= 1'b0;
         smp_valid_r <= 1'b0;
         ld_ready_r  <= 1'b0;
         ld_done_r   <= 1'b0;
         table_valid <= 1'b0;
      end else begin
         cen_r     <= 1'b1;
         wen_r     <= 1'b1;
         ld_done_r <= 1'b0;
         vld_p1    <= rd_issue;

         // p1 -> output: sign and valid land with the SRAM's registered Q
         sign_r      <= sign_p1;
         smp_valid_r <= vld_p1;

         if (ld_enter) begin
            table_valid <= 1'b0;
            ld_cnt      <= '0;
            ld_ready_r  <= 1'b1;
         end

         if (ld_xfer) begin
            cen_r     <= 1'b0;
            wen_r     <= 1'b0;
            index_r   <= ld_cnt;
            data_wr_r <= bus.ld_data;
            ld_cnt    <= ld_cnt + ADDR_W'(1);
            if (ld_cnt == LAST_ADDR) begin
               ld_ready_r  <= 1'b0;
               ld_done_r   <= 1'b1;
               table_valid <= 1'b1;
            end
         end

         // p0 -> p1: issue the read and advance the accumulator
         if (rd_issue) begin
            cen_r   <= 1'b0;
            index_r <= phase_to_index(phase_p0);
            sign_p1 <= phase_p0[ACC_W-1];
            acc     <= acc + fcw;
         end

         if (phase_clr)
            acc <= '0;
      end
   end

   assign bus.ld_ready  = ld_ready_r;
   assign bus.ld_done   = ld_done_r;
   assign bus.cen       = cen_r;
   assign bus.wen       = wen_r;
   assign bus.index     = index_r;
   assign bus.data_wr   = data_wr_r;
   assign bus.sign      = sign_r;
   assign bus.smp_valid = smp_valid_r;

endmodule

// File: tb/tb_dds_lut_ctrl.sv
`timescale 1ns/1ps
// Bench for dds_lut_ctrl: directed load/run sequence plus a randomized run segment,
// scored against an arithmetic phase model of the accumulator and table addressing.
module tb_dds_lut_ctrl;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic             sys_clk = 1'b0;
   logic             reset;
   logic [ACC_W-1:0] fcw;
   logic [ACC_W-1:0] phase_off;
   logic             phase_clr;
   logic             run_en;
   logic             ld_start;
   logic             table_valid;

   int npass = 0;
   int nfail = 0;
   int nchk  = 0;

   // reference model state
   logic [31:0] m_acc;
   bit          m_run;
   bit          m_tv;
   bit          m_prev_issue;
   bit          m_prev_sign;
`ifdef PHASE_DITHER_EN
   logic [15:0] m_lfsr;
`endif

   dds_lut_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dds_lut_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .fcw         (fcw),
      .phase_off   (phase_off),
      .phase_clr   (phase_clr),
      .run_en      (run_en),
      .ld_start    (ld_start),
      .table_valid (table_valid),
      .bus         (bus)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef PHASE_DITHER_EN
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction
`endif

   task automatic m_reset();
      m_acc        = 32'd0;
      m_run        = 1'b0;
      m_tv         = 1'b0;
      m_prev_issue = 1'b0;
      m_prev_sign  = 1'b0;
`ifdef PHASE_DITHER_EN
      m_lfsr = 16'hACE1;
`endif
   endtask

   task automatic chk_reset(input string t);
      chk({t, "_cen"},       64'(bus.cen),       64'd1);
      chk({t, "_wen"},       64'(bus.wen),       64'd1);
      chk({t, "_index"},     64'(bus.index),     64'd0);
      chk({t, "_data_wr"},   64'(bus.data_wr),   64'd0);
      chk({t, "_sign"},      64'(bus.sign),      64'd0);
      chk({t, "_smp_valid"}, 64'(bus.smp_valid), 64'd0);
      chk({t, "_ld_ready"},  64'(bus.ld_ready),  64'd0);
      chk({t, "_ld_done"},   64'(bus.ld_done),   64'd0);
      chk({t, "_tv"},        64'(table_valid),   64'd0);
   endtask

   // One cycle of streaming: expected read address is phase / 2^17 mod depth,
   // sign is the upper half of the phase circle.
   task automatic step_run(input logic [31:0] f, input logic [31:0] o, input bit clr, input bit re);
      logic [31:0] p;
      logic [31:0] e_idx;
      bit          issue;
      fcw       = f;
      phase_off = o;
      phase_clr = clr;
      run_en    = re;
      issue     = m_run && re;
`ifdef PHASE_DITHER_EN
      p = m_acc + o + {16'd0, m_lfsr};
`else
      p = m_acc + o;
`endif
      e_idx = (p / 32'h0002_0000) % 32'(DEPTH);
      tick();
      chk("run_cen", 64'(bus.cen), issue ? 64'd0 : 64'd1);
      if (issue) begin
         chk("run_index", 64'(bus.index), 64'(e_idx));
         chk("run_wen", 64'(bus.wen), 64'd1);
      end
      chk("run_smp_valid", 64'(bus.smp_valid), 64'(m_prev_issue));
      if (m_prev_issue)
         chk("run_sign", 64'(bus.sign), 64'(m_prev_sign));
      m_prev_issue = issue;
      if (issue)
         m_prev_sign = (p >= 32'h8000_0000);
      if (clr)
         m_acc = 32'd0;
      else if (issue)
         m_acc = m_acc + f;
`ifdef PHASE_DITHER_EN
      if (m_run)
         m_lfsr = lfsr_next(m_lfsr);
`endif
      m_run     = re && (m_run || m_tv);
      phase_clr = 1'b0;
   endtask

   task automatic do_load(input bit start, input bit gapped, input int limit);
      int          k;
      int          cyc;
      bit          v;
      logic [15:0] d;
      k   = 0;
      cyc = 0;
      if (start) begin
         ld_start = 1'b1;
         tick();
         ld_start = 1'b0;
         chk("ld_entry_ready", 64'(bus.ld_ready), 64'd1);
         chk("ld_entry_tv",    64'(table_valid),  64'd0);
         chk("ld_entry_cen",   64'(bus.cen),      64'd1);
      end
      while (k < limit && cyc < 4 * DEPTH) begin
         v = gapped ? (cyc % 2 == 0) : 1'b1;
         d = gapped ? 16'($urandom) : 16'(k);
         bus.ld_valid = v;
         bus.ld_data  = d;
         chk("ld_ready", 64'(bus.ld_ready), 64'd1);
         tick();
         cyc++;
         if (v) begin
            chk("ld_cen",     64'(bus.cen),     64'd0);
            chk("ld_wen",     64'(bus.wen),     64'd0);
            chk("ld_index",   64'(bus.index),   64'(k));
            chk("ld_data_wr", 64'(bus.data_wr), 64'(d));
            k++;
            chk("ld_done", 64'(bus.ld_done), (k == DEPTH) ? 64'd1 : 64'd0);
         end else begin
            chk("ld_gap_cen", 64'(bus.cen),     64'd1);
            chk("ld_gap_wen", 64'(bus.wen),     64'd1);
            chk("ld_gap_done", 64'(bus.ld_done), 64'd0);
         end
         chk("ld_smp_valid", 64'(bus.smp_valid), 64'd0);
      end
      bus.ld_valid = 1'b0;
      chk("ld_word_count", 64'(k), 64'(limit));
      if (limit == DEPTH) begin
         chk("ld_last_ready", 64'(bus.ld_ready), 64'd0);
         chk("ld_last_tv",    64'(table_valid),  64'd1);
         bus.ld_valid = 1'b1;
         tick();
         bus.ld_valid = 1'b0;
         chk("ld_post_done",  64'(bus.ld_done),  64'd0);
         chk("ld_post_cen",   64'(bus.cen),      64'd1);
         chk("ld_post_tv",    64'(table_valid),  64'd1);
         chk("ld_post_ready", 64'(bus.ld_ready), 64'd0);
      end
   endtask

   initial begin
      logic [31:0] rf;
      logic [31:0] ro;
      bit          rc;
      bit          rr;
      reset        = 1'b1;
      fcw          = '0;
      phase_off    = '0;
      phase_clr    = 1'b0;
      run_en       = 1'b0;
      ld_start     = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_data  = '0;
      m_reset();
      repeat (3) tick();
      chk_reset("por");
      reset = 1'b0;

      // abort a load after 100 words
      do_load(1'b1, 1'b0, 100);
      bus.ld_valid = 1'b1;
      reset = 1'b1;
      tick();
      bus.ld_valid = 1'b0;
      chk_reset("rst_mid_load");
      reset = 1'b0;
      m_reset();

      // run request without a loaded table stays idle
      repeat (4) step_run(32'h0002_0000, 32'h0, 1'b0, 1'b1);
      step_run(32'h0, 32'h0, 1'b0, 1'b0);

      // full continuous load restarting at index 0
      do_load(1'b1, 1'b0, DEPTH);
      m_tv = 1'b1;

      // linear sweep through the half-wave and into the negative half
      repeat (DEPTH + 20) step_run(32'h0002_0000, 32'h0, 1'b0, 1'b1);
      step_run(32'h0002_0000, 32'h0, 1'b1, 1'b1);
      repeat (8) step_run(32'h0002_0000, 32'hFFF8_0000, 1'b0, 1'b1);

      // half-rate and quarter-offset tones
      step_run(32'h8000_0000, 32'h0, 1'b1, 1'b1);
      repeat (6) step_run(32'h8000_0000, 32'h0, 1'b0, 1'b1);
      repeat (6) step_run(32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1);
      repeat (4) step_run(32'h0, 32'h1234_5678, 1'b0, 1'b1);

      repeat (400) begin
         rf = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         ro = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         rc = ($urandom_range(0, 15) == 0);
         rr = ($urandom_range(0, 9) != 0);
         step_run(rf, ro, rc, rr);
      end

      // leave and re-enter RUN
      repeat (2) step_run(32'h0002_0000, 32'h0, 1'b0, 1'b0);
      repeat (3) step_run(32'h0002_0000, 32'h0, 1'b0, 1'b1);

      // reload requested while streaming
      ld_start = 1'b1;
      run_en   = 1'b1;
      tick();
      ld_start = 1'b0;
      run_en   = 1'b0;
      chk("mid_run_tv",    64'(table_valid),   64'd0);
      chk("mid_run_cen",   64'(bus.cen),       64'd1);
      chk("mid_run_ready", 64'(bus.ld_ready),  64'd1);
      chk("mid_run_trail", 64'(bus.smp_valid), 64'(m_prev_issue));
      if (m_prev_issue)
         chk("mid_run_sign", 64'(bus.sign), 64'(m_prev_sign));
`ifdef PHASE_DITHER_EN
      if (m_run)
         m_lfsr = lfsr_next(m_lfsr);
`endif
      m_run        = 1'b0;
      m_tv         = 1'b0;
      m_prev_issue = 1'b0;
      do_load(1'b0, 1'b1, DEPTH);
      m_tv = 1'b1;

      // resume continues from the preserved accumulator
      repeat (12) step_run(32'h0002_0000, 32'h0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
